timer_multi: RTL and testbench
==============================

# timer_multi

Parametrised multi-channel down-counter timer; the next generation of the team's single-channel timer IP. It provides NCH independent channels, each with a programmable counter width, prescaler, one-shot/periodic mode, sticky timeout status and an interrupt enable. Channels share one registered bus port and one OR-combined interrupt line. The block sits on the same memory-mapped peripheral bus as the existing timer.

## Interface

Parameters:
- NCH, 4, number of channels (1..16)
- WIDTH, 32, counter/LOAD/VALUE width (8..32)
- PRESC_W, 8, prescaler divider width (1..16)
- AW, $clog2(NCH)+2, address width (derived; do not override)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- sel  input  1  block selected
- wr_en  input  1  write strobe, qualified by sel
- rd_en  input  1  read strobe, qualified by sel
- addr  input  AW  addr[AW-1:2] = channel, addr[1:0] = register
- wdata  input  32  write data
- rdata  output  32  registered read data
- timeout_o  output  NCH  per-channel sticky timeout flag
- irq_o  output  1  OR over channels of (timeout & IE)

## Operation

- Register map per channel: 0 CTRL (R/W), 1 LOAD (R/W, low WIDTH bits, upper bits read 0), 2 VALUE (RO; writes ignored), 3 STATUS (bit0 timeout, W1C).
- CTRL fields: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] PRESC_EN, [3] IE, [8 +: PRESC_W] PRESC_DIV. Other bits read 0.
- Channel index >= NCH: writes ignored, reads return 0.
- EN=0: VALUE <= LOAD every cycle, prescaler counter <= 0. STATUS is kept (not cleared by disable).
- EN=1: a tick occurs when PRESC_EN=0, or when presc_cnt == PRESC_DIV (then presc_cnt <= 0); otherwise presc_cnt increments.
- On tick:
  - VALUE > 1: decrement.
  - VALUE == 1: set timeout. Periodic: VALUE <= LOAD. One-shot: VALUE <= 0 and hardware clears CTRL.EN.
  - VALUE == 0: periodic reloads LOAD with no timeout; one-shot clears EN with no timeout.
- LOAD written while running is used only at the next reload.
- Simultaneous events:
  - Timeout set and STATUS W1C in the same cycle: the set wins.
  - Hardware EN-clear and a bus CTRL write in the same cycle: the bus write wins.
- Channels are fully independent; no cross-channel state except irq_o.

## Timing

- Reset (async assert, sync-safe release): CTRL, LOAD, VALUE, presc_cnt, status, rdata all 0. timeout_o = 0, irq_o = 0.
- Writes take effect at the clock edge where sel & wr_en is high.
- Read latency is 1 cycle: rdata updates at the edge where sel & rd_en is high and holds otherwise. The value returned is the pre-edge register value.
- EN written at edge N, with PRESC_EN=0 and LOAD=L≥1: VALUE=L-1 after edge N+1. timeout_o rises after edge N+L.
- With PRESC_EN=1 and PRESC_DIV=D, ticks occur every D+1 cycles. The first tick is at edge N+1+D, so timeout rises after edge N+L·(D+1).
- Periodic mode: timeout repeats every L ticks. VALUE sequence is L-1 … 1, L, L-1, ….
- irq_o is combinational from the timeout and IE registers; there is no extra latency.

## Test plan

- Reset mid-count: ch0 LOAD=10, EN=1. Assert rst at VALUE=5 -> all registers, rdata, timeout_o and irq_o read 0 immediately; after release, ch0 stays idle.
- One-shot: ch1 LOAD=4, CTRL=0x1 -> timeout_o[1] rises exactly 4 cycles after the write edge. VALUE is 0 for one cycle, then 4. CTRL reads 0x0. irq_o stays 0 because IE=0.
- Periodic + prescaler + IRQ: ch2 LOAD=3, CTRL=0x020F (PRESC_DIV=2) -> first timeout after 9 cycles and irq_o=1. W1C STATUS=1 clears it; it sets again 9 cycles later.
- W1C collision: periodic ch0 LOAD=2; issue STATUS W1C on the same edge as the timeout set -> STATUS reads 1.
- LOAD update and LOAD=0: change LOAD 5→2 mid-count in periodic mode -> the current period finishes at 5 and the next period is 2. With periodic LOAD=0 -> VALUE stays 0 and timeout never sets.
- Addressing: NCH=4, each channel given a distinct LOAD; access an invalid address (parameter NCH=3, channel 3) -> each channel reads back its own value; the invalid channel reads 0 and a write to it has no effect; a VALUE write is ignored.

Source files
------------

// File: rtl/timer_multi_if.sv
// Register-bus bundle for timer_multi: select, strobes, address, write data, registered read data.
interface timer_multi_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = $clog2(NCH) + 2
);
  logic          sel;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (output sel, wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input sel, wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/timer_multi.sv
// Multi-channel prescaled down-counter timer with one-shot/periodic modes,
// sticky W1C timeout status per channel and an OR-combined interrupt.
module timer_multi #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned AW      = $clog2(NCH) + 2
) (
  input  logic            clk,
  input  logic            rst,
  timer_multi_if.slave    bus,
  output logic [NCH-1:0]  timeout_o,
  output logic            irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [NCH-1:0]     en_q, en_d;
  logic [NCH-1:0]     mode_q, mode_d;
  logic [NCH-1:0]     pen_q, pen_d;
  logic [NCH-1:0]     ie_q, ie_d;
  logic [NCH-1:0]     status_q, status_d;
  logic [PRESC_W-1:0] div_q   [NCH];
  logic [PRESC_W-1:0] div_d   [NCH];
  logic [PRESC_W-1:0] presc_q [NCH];
  logic [PRESC_W-1:0] presc_d [NCH];
  logic [WIDTH-1:0]   load_q  [NCH];
  logic [WIDTH-1:0]   load_d  [NCH];
  logic [WIDTH-1:0]   value_q [NCH];
  logic [WIDTH-1:0]   value_d [NCH];
  logic [31:0]        rdata_q, rdata_d;

  logic [AW-1:0]      ch_c;
  logic [1:0]         reg_c;
  logic               valid_c;
  logic               wr_c;
  logic               rd_c;
  logic [NCH-1:0]     hit_c;
  logic [NCH-1:0]     tick_c;
  logic [NCH-1:0]     set_c;
  logic               unused_wdata_c;

  assign ch_c           = bus.addr >> 2;
  assign reg_c          = bus.addr[1:0];
  assign valid_c        = 32'(ch_c) < NCH;
  assign wr_c           = bus.sel & bus.wr_en & valid_c;
  assign rd_c           = bus.sel & bus.rd_en & valid_c;
  assign unused_wdata_c = ^bus.wdata;

  // Per-channel counting, then bus writes layered on top so they take priority.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    pen_d    = pen_q;
    ie_d     = ie_q;
    status_d = status_q;
    hit_c    = '0;
    tick_c   = '0;
    set_c    = '0;
    for (int i = 0; i < NCH; i++) begin
      div_d[i]   = div_q[i];
      load_d[i]  = load_q[i];
      value_d[i] = value_q[i];
      presc_d[i] = presc_q[i];
      hit_c[i]   = wr_c && (ch_c == AW'(i));

      if (!en_q[i]) begin
        value_d[i] = load_q[i];
        presc_d[i] = '0;
      end else begin
        tick_c[i]  = !pen_q[i] || (presc_q[i] == div_q[i]);
        presc_d[i] = tick_c[i] ? '0 : presc_q[i] + PRESC_W'(1);
        if (tick_c[i]) begin
          if (value_q[i] > WIDTH'(1)) begin
            value_d[i] = value_q[i] - WIDTH'(1);
          end else begin
            set_c[i] = (value_q[i] == WIDTH'(1));
            if (mode_q[i]) begin
              value_d[i] = load_q[i];
            end else begin
              value_d[i] = '0;
              en_d[i]    = 1'b0;
            end
          end
        end
      end

      if (hit_c[i]) begin
        case (reg_c)
          REG_CTRL: begin
            en_d[i]   = bus.wdata[0];
            mode_d[i] = bus.wdata[1];
            pen_d[i]  = bus.wdata[2];
            ie_d[i]   = bus.wdata[3];
            div_d[i]  = bus.wdata[8 +: PRESC_W];
          end
          REG_LOAD:   load_d[i] = bus.wdata[WIDTH-1:0];
          REG_STATUS: if (bus.wdata[0]) status_d[i] = 1'b0;
          default: ;
        endcase
      end

      // A timeout landing on the same edge as a W1C must not be lost.
      if (set_c[i]) status_d[i] = 1'b1;
    end
  end

  // Read mux returns pre-edge register contents; invalid channels read zero.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.sel && bus.rd_en) begin
      rdata_d = '0;
      if (rd_c) begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_c == AW'(i)) begin
            case (reg_c)
              REG_CTRL: begin
                rdata_d[0]             = en_q[i];
                rdata_d[1]             = mode_q[i];
                rdata_d[2]             = pen_q[i];
                rdata_d[3]             = ie_q[i];
                rdata_d[8 +: PRESC_W]  = div_q[i];
              end
              REG_LOAD:   rdata_d[WIDTH-1:0] = load_q[i];
              REG_VALUE:  rdata_d[WIDTH-1:0] = value_q[i];
              REG_STATUS: rdata_d[0]         = status_q[i];
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= '0;
      mode_q   <= '0;
      pen_q    <= '0;
      ie_q     <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i]   <= '0;
        presc_q[i] <= '0;
        load_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      pen_q    <= pen_d;
      ie_q     <= ie_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < NCH; i++) begin
        div_q[i]   <= div_d[i];
        presc_q[i] <= presc_d[i];
        load_q[i]  <= load_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign timeout_o = status_q;
  assign irq_o     = |(status_q & ie_q);

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: a 4-channel 32-bit instance plus a 3-channel 8-bit instance for addressing.
module tb_timer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] to_a;
  logic       irq_a;
  logic [2:0] to_b;
  logic       irq_b;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  timer_multi_if #(.NCH(4)) bus_a ();
  timer_multi_if #(.NCH(3)) bus_b ();

  timer_multi #(.NCH(4), .WIDTH(32), .PRESC_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .timeout_o(to_a), .irq_o(irq_a));

  timer_multi #(.NCH(3), .WIDTH(8), .PRESC_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .timeout_o(to_b), .irq_o(irq_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus_a.sel = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    bus_b.sel = 1'b0; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
  endtask

  // Each access consumes exactly one rising edge and returns 1 time unit after it.
  task automatic wr(input bit b, input logic [3:0] a, input logic [31:0] v);
    if (b) begin
      bus_b.sel = 1'b1; bus_b.wr_en = 1'b1; bus_b.addr = a; bus_b.wdata = v;
    end else begin
      bus_a.sel = 1'b1; bus_a.wr_en = 1'b1; bus_a.addr = a; bus_a.wdata = v;
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic rd(input bit b, input logic [3:0] a, output logic [31:0] v);
    if (b) begin
      bus_b.sel = 1'b1; bus_b.rd_en = 1'b1; bus_b.addr = a;
    end else begin
      bus_a.sel = 1'b1; bus_a.rd_en = 1'b1; bus_a.addr = a;
    end
    @(posedge clk); #1;
    v = b ? bus_b.rdata : bus_a.rdata;
    idle_bus();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle_bus();
    bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.addr = '0; bus_b.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    chk("reset_timeout", 32'(to_a), 32'h0);
    chk("reset_irq", 32'(irq_a), 32'h0);
    chk("reset_rdata", bus_a.rdata, 32'h0);

    // Reset mid-count on ch0
    wr(0, 4'd1, 32'd10);
    wr(0, 4'd0, 32'h1);
    cyc(5);
    rd(0, 4'd2, d);
    chk("midcount_value5", d, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdata", bus_a.rdata, 32'h0);
    chk("async_rst_timeout", 32'(to_a), 32'h0);
    chk("async_rst_irq", 32'(irq_a), 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rd(0, 4'd0, d); chk("post_rst_ctrl", d, 32'h0);
    rd(0, 4'd1, d); chk("post_rst_load", d, 32'h0);
    cyc(5);
    rd(0, 4'd2, d); chk("post_rst_idle_value", d, 32'h0);
    rd(0, 4'd3, d); chk("post_rst_status", d, 32'h0);

    // One-shot ch1, LOAD=4
    wr(0, 4'd5, 32'd4);
    wr(0, 4'd4, 32'h1);
    cyc(3);
    chk("oneshot_before", 32'(to_a[1]), 32'h0);
    cyc(1);
    chk("oneshot_timeout", 32'(to_a[1]), 32'h1);
    chk("oneshot_no_irq", 32'(irq_a), 32'h0);
    rd(0, 4'd6, d); chk("oneshot_value0", d, 32'd0);
    rd(0, 4'd6, d); chk("oneshot_value_reload", d, 32'd4);
    rd(0, 4'd4, d); chk("oneshot_en_cleared", d, 32'h0);
    wr(0, 4'd7, 32'h1);
    chk("oneshot_w1c", 32'(to_a[1]), 32'h0);

    // Periodic ch2 with prescaler 2 and IE
    wr(0, 4'd9, 32'd3);
    wr(0, 4'd8, 32'h020F);
    cyc(8);
    chk("presc_before", 32'(to_a[2]), 32'h0);
    chk("presc_irq_before", 32'(irq_a), 32'h0);
    cyc(1);
    chk("presc_timeout", 32'(to_a[2]), 32'h1);
    chk("presc_irq", 32'(irq_a), 32'h1);
    wr(0, 4'd11, 32'h1);
    chk("presc_w1c", 32'(to_a[2]), 32'h0);
    chk("presc_irq_cleared", 32'(irq_a), 32'h0);
    cyc(7);
    chk("presc_second_before", 32'(to_a[2]), 32'h0);
    cyc(1);
    chk("presc_second_timeout", 32'(to_a[2]), 32'h1);
    wr(0, 4'd8, 32'h0);
    rd(0, 4'd11, d); chk("status_kept_on_disable", d, 32'h1);
    wr(0, 4'd11, 32'h1);
    chk("ch2_cleared_irq", 32'(irq_a), 32'h0);

    // W1C collides with timeout set on ch0
    wr(0, 4'd1, 32'd2);
    wr(0, 4'd0, 32'h3);
    cyc(1);
    wr(0, 4'd3, 32'h1);
    chk("collision_timeout", 32'(to_a[0]), 32'h1);
    rd(0, 4'd3, d); chk("collision_status", d, 32'h1);
    wr(0, 4'd0, 32'h0);
    wr(0, 4'd3, 32'h1);
    chk("collision_cleared", 32'(to_a[0]), 32'h0);

    // LOAD change mid-count on periodic ch3, then LOAD=0
    wr(0, 4'd13, 32'd5);
    wr(0, 4'd12, 32'h3);
    cyc(1);
    wr(0, 4'd13, 32'd2);
    cyc(2);
    chk("reload_before", 32'(to_a[3]), 32'h0);
    cyc(1);
    chk("reload_period5", 32'(to_a[3]), 32'h1);
    wr(0, 4'd15, 32'h1);
    chk("reload_w1c", 32'(to_a[3]), 32'h0);
    cyc(1);
    chk("reload_period2", 32'(to_a[3]), 32'h1);
    wr(0, 4'd12, 32'h0);
    wr(0, 4'd15, 32'h1);
    wr(0, 4'd13, 32'd0);
    wr(0, 4'd12, 32'h3);
    cyc(10);
    chk("load0_no_timeout", 32'(to_a[3]), 32'h0);
    rd(0, 4'd14, d); chk("load0_value", d, 32'd0);
    wr(0, 4'd12, 32'h0);

    // Addressing on the 4-channel instance
    wr(0, 4'd1,  32'h11);
    wr(0, 4'd5,  32'h22);
    wr(0, 4'd9,  32'h33);
    wr(0, 4'd13, 32'h44);
    rd(0, 4'd1,  d); chk("addr_ch0_load", d, 32'h11);
    rd(0, 4'd5,  d); chk("addr_ch1_load", d, 32'h22);
    rd(0, 4'd9,  d); chk("addr_ch2_load", d, 32'h33);
    rd(0, 4'd13, d); chk("addr_ch3_load", d, 32'h44);
    wr(0, 4'd2, 32'hDEAD);
    rd(0, 4'd2, d); chk("value_write_ignored", d, 32'h11);
    wr(0, 4'd0, 32'hFFFF_FFF0);
    rd(0, 4'd0, d); chk("ctrl_reserved_zero", d, 32'h0000_FF00);
    wr(0, 4'd0, 32'h0);

    // Invalid channel and narrow widths on the 3-channel instance
    wr(1, 4'd1,  32'hA0);
    wr(1, 4'd5,  32'hA1);
    wr(1, 4'd9,  32'h1A2);
    wr(1, 4'd13, 32'h55);
    wr(1, 4'd12, 32'h3);
    rd(1, 4'd13, d); chk("inv_load_read0", d, 32'h0);
    rd(1, 4'd12, d); chk("inv_ctrl_read0", d, 32'h0);
    rd(1, 4'd1,  d); chk("b_ch0_load", d, 32'hA0);
    rd(1, 4'd5,  d); chk("b_ch1_load", d, 32'hA1);
    rd(1, 4'd9,  d); chk("b_ch2_load_trunc", d, 32'hA2);
    wr(1, 4'd0, 32'hFFFF_FFF0);
    rd(1, 4'd0, d); chk("b_ctrl_reserved_zero", d, 32'h0000_0F00);
    chk("b_no_timeout", 32'(to_b), 32'h0);
    chk("b_no_irq", 32'(irq_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
